// File: rtl/game_pkg.sv
// Shared definitions for the stacker game blocks.
// Holds the FSM state encoding, the default play-field and block constants
// (so that stack_ctrl, stack and draw agree), and the landing-line helper.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SWING    = 3'd1,
        S_DROP     = 3'd2,
        S_ALIGN    = 3'd3,
        S_PAUSED   = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    localparam int FIELD_W_DEF    = 640;
    localparam int FIELD_H_DEF    = 480;
    localparam int BLOCK_H_DEF    = 16;
    localparam int INIT_W_DEF     = 160;
    localparam int SWING_STEP_DEF = 4;
    localparam int FALL_STEP_DEF  = 8;
    localparam int MAX_LEVEL_DEF  = 24;

    localparam int COORD_W = 10;   // pixel coordinates and widths
    localparam int SUM_W   = 11;   // one extra bit for edge sums
    localparam int LEVEL_W = 5;
    localparam int SCORE_W = 10;

    // Top edge at which a block dropped onto a tower of 'lvl' placed blocks
    // comes to rest: one row for the base, one for the block itself.
    function automatic logic [SUM_W-1:0] land_line(
        input logic [LEVEL_W-1:0] lvl,
        input logic [SUM_W-1:0]   field_h,
        input logic [SUM_W-1:0]   block_h
    );
        logic [SUM_W-1:0] rows;
        rows = {{(SUM_W-LEVEL_W){1'b0}}, lvl} + 11'd2;
        return field_h - rows * block_h;
    endfunction

endpackage

// File: rtl/overlap_calc.sv
// Combinational overlap of the dropped block against the tower top.
// Ports:
//   pos_x, width  : dropped block left edge and width
//   top_x, top_w  : tower top left edge and width
//   left          : left edge of the overlap, max(pos_x, top_x)
//   ovl_w         : overlap width, valid only when miss is low
//   miss          : no horizontal overlap at all (touching edges count as a miss)
module overlap_calc
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] top_x,
    input  logic [COORD_W-1:0] top_w,
    output logic [COORD_W-1:0] left,
    output logic [COORD_W-1:0] ovl_w,
    output logic               miss
);

    logic [SUM_W-1:0] right_blk;
    logic [SUM_W-1:0] right_top;
    logic [SUM_W-1:0] left_ext;
    logic [SUM_W-1:0] right_ext;

    assign right_blk = {1'b0, pos_x} + {1'b0, width};
    assign right_top = {1'b0, top_x} + {1'b0, top_w};

    assign left      = (pos_x >= top_x) ? pos_x : top_x;
    assign left_ext  = {1'b0, left};
    assign right_ext = (right_blk <= right_top) ? right_blk : right_top;

    assign miss  = (right_ext <= left_ext);
    assign ovl_w = COORD_W'(right_ext - left_ext);

endmodule

// File: rtl/stack_ctrl.sv
// Game-sequencing controller for the stacker game.
// Runs the swing -> drop -> align loop on the divided game tick and the
// start/pause buttons, and owns all moving-block and tower geometry.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   tick                : one-cycle game-rate enable
//   start, pause        : one-cycle debounced button pulses
//   pos_x, pos_y, width : moving block geometry
//   top_x, top_w        : tower top geometry
//   level, score        : placed blocks above the base, saturating score
//   state               : FSM state (game_pkg::state_t encoding)
//   game_over, win      : end-of-game flags
module stack_ctrl
    import game_pkg::*;
#(
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter int FIELD_H    = FIELD_H_DEF,
    parameter int BLOCK_H    = BLOCK_H_DEF,
    parameter int INIT_W     = INIT_W_DEF,
    parameter int SWING_STEP = SWING_STEP_DEF,
    parameter int FALL_STEP  = FALL_STEP_DEF,
    parameter int MAX_LEVEL  = MAX_LEVEL_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                pause,
    output logic [COORD_W-1:0]  pos_x,
    output logic [COORD_W-1:0]  pos_y,
    output logic [COORD_W-1:0]  width,
    output logic [COORD_W-1:0]  top_x,
    output logic [COORD_W-1:0]  top_w,
    output logic [LEVEL_W-1:0]  level,
    output logic [SCORE_W-1:0]  score,
    output logic [2:0]          state,
    output logic                game_over,
    output logic                win
);

    localparam logic [SUM_W-1:0]   FIELD_W_S   = SUM_W'(FIELD_W);
    localparam logic [SUM_W-1:0]   FIELD_H_S   = SUM_W'(FIELD_H);
    localparam logic [SUM_W-1:0]   BLOCK_H_S   = SUM_W'(BLOCK_H);
    localparam logic [SUM_W-1:0]   SWING_S     = SUM_W'(SWING_STEP);
    localparam logic [SUM_W-1:0]   FALL_S      = SUM_W'(FALL_STEP);
    localparam logic [COORD_W-1:0] FIELD_W_C   = COORD_W'(FIELD_W);
    localparam logic [COORD_W-1:0] SWING_C     = COORD_W'(SWING_STEP);
    localparam logic [COORD_W-1:0] FALL_C      = COORD_W'(FALL_STEP);
    localparam logic [COORD_W-1:0] INIT_W_C    = COORD_W'(INIT_W);
    localparam logic [COORD_W-1:0] TOP_X_INIT  = COORD_W'((FIELD_W - INIT_W) / 2);
    localparam logic [LEVEL_W-1:0] MAX_LEVEL_C = LEVEL_W'(MAX_LEVEL);
    localparam logic [SUM_W-1:0]   SCORE_MAX   = SUM_W'((1 << SCORE_W) - 1);

    state_t state_reg, state_next;
    state_t ret_reg,   ret_next;     // where PAUSED returns to

    logic [COORD_W-1:0] pos_x_reg, pos_x_next;
    logic [COORD_W-1:0] pos_y_reg, pos_y_next;
    logic [COORD_W-1:0] width_reg, width_next;
    logic [COORD_W-1:0] top_x_reg, top_x_next;
    logic [COORD_W-1:0] top_w_reg, top_w_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               dir_right_reg, dir_right_next;
    logic               game_over_reg, game_over_next;
    logic               win_reg, win_next;

    // Datapath helpers
    logic [SUM_W-1:0]   swing_edge;
    logic               hit_right;
    logic               hit_left;
    logic [SUM_W-1:0]   y_land;
    logic               landed;
    logic [COORD_W-1:0] ovl_left;
    logic [COORD_W-1:0] ovl_w;
    logic               miss;
    logic               perfect;
    logic [LEVEL_W-1:0] level_inc;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    assign swing_edge = {1'b0, pos_x_reg} + {1'b0, width_reg} + SWING_S;
    assign hit_right  = (swing_edge > FIELD_W_S);
    assign hit_left   = (pos_x_reg < SWING_C);

    assign y_land = land_line(level_reg, FIELD_H_S, BLOCK_H_S);
    assign landed = (({1'b0, pos_y_reg} + FALL_S) >= y_land);

    overlap_calc u_overlap (
        .pos_x (pos_x_reg),
        .width (width_reg),
        .top_x (top_x_reg),
        .top_w (top_w_reg),
        .left  (ovl_left),
        .ovl_w (ovl_w),
        .miss  (miss)
    );

    assign perfect   = (pos_x_reg == top_x_reg);
    assign level_inc = level_reg + 5'd1;
    assign score_sum = {1'b0, score_reg} + (perfect ? 11'd2 : 11'd1);
    assign score_sat = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                               : score_sum[SCORE_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; pause wins over start and tick wherever it applies
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_SWING;
            end
            S_SWING: begin
                if (pause)      state_next = S_PAUSED;
                else if (start) state_next = S_DROP;
            end
            S_DROP: begin
                if (pause)              state_next = S_PAUSED;
                else if (tick && landed) state_next = S_ALIGN;
            end
            S_ALIGN: begin
                if (miss || level_inc == MAX_LEVEL_C) state_next = S_GAMEOVER;
                else                                  state_next = S_SWING;
            end
            S_PAUSED: begin
                if (pause) state_next = ret_reg;
            end
            S_GAMEOVER: begin
                if (start) state_next = S_SWING;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output / geometry next-value logic
    always_comb begin
        ret_next       = ret_reg;
        pos_x_next     = pos_x_reg;
        pos_y_next     = pos_y_reg;
        width_next     = width_reg;
        top_x_next     = top_x_reg;
        top_w_next     = top_w_reg;
        level_next     = level_reg;
        score_next     = score_reg;
        dir_right_next = dir_right_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    pos_x_next     = '0;
                    pos_y_next     = '0;
                    dir_right_next = 1'b1;
                end
            end
            S_SWING: begin
                if (pause) begin
                    ret_next = S_SWING;
                end else if (tick && !start) begin
                    // At an edge the block is clamped and turns around; the
                    // next tick then moves it back the other way.
                    if (dir_right_reg) begin
                        if (hit_right) begin
                            pos_x_next     = FIELD_W_C - width_reg;
                            dir_right_next = 1'b0;
                        end else begin
                            pos_x_next = pos_x_reg + SWING_C;
                        end
                    end else begin
                        if (hit_left) begin
                            pos_x_next     = '0;
                            dir_right_next = 1'b1;
                        end else begin
                            pos_x_next = pos_x_reg - SWING_C;
                        end
                    end
                end
            end
            S_DROP: begin
                if (pause) begin
                    ret_next = S_DROP;
                end else if (tick) begin
                    pos_y_next = landed ? y_land[COORD_W-1:0] : pos_y_reg + FALL_C;
                end
            end
            S_ALIGN: begin
                if (!miss) begin
                    top_x_next = ovl_left;
                    top_w_next = ovl_w;
                    width_next = ovl_w;
                    level_next = level_inc;
                    score_next = score_sat;
                    if (level_inc != MAX_LEVEL_C) begin
                        pos_x_next     = '0;
                        pos_y_next     = '0;
                        dir_right_next = 1'b1;
                    end
                end
            end
            S_GAMEOVER: begin
                if (start) begin
                    pos_x_next     = '0;
                    pos_y_next     = '0;
                    width_next     = INIT_W_C;
                    top_x_next     = TOP_X_INIT;
                    top_w_next     = INIT_W_C;
                    level_next     = '0;
                    score_next     = '0;
                    dir_right_next = 1'b1;
                end
            end
            default: ;
        endcase

        // Flags are registered against the state being entered so they line
        // up with the state output.
        game_over_next = (state_next == S_GAMEOVER);
        win_next       = (state_next == S_GAMEOVER) && (level_next == MAX_LEVEL_C);
    end

    // Geometry and flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ret_reg       <= S_IDLE;
            pos_x_reg     <= '0;
            pos_y_reg     <= '0;
            width_reg     <= INIT_W_C;
            top_x_reg     <= TOP_X_INIT;
            top_w_reg     <= INIT_W_C;
            level_reg     <= '0;
            score_reg     <= '0;
            dir_right_reg <= 1'b1;
            game_over_reg <= 1'b0;
            win_reg       <= 1'b0;
        end else begin
            ret_reg       <= ret_next;
            pos_x_reg     <= pos_x_next;
            pos_y_reg     <= pos_y_next;
            width_reg     <= width_next;
            top_x_reg     <= top_x_next;
            top_w_reg     <= top_w_next;
            level_reg     <= level_next;
            score_reg     <= score_next;
            dir_right_reg <= dir_right_next;
            game_over_reg <= game_over_next;
            win_reg       <= win_next;
        end
    end

    assign pos_x     = pos_x_reg;
    assign pos_y     = pos_y_reg;
    assign width     = width_reg;
    assign top_x     = top_x_reg;
    assign top_w     = top_w_reg;
    assign level     = level_reg;
    assign score     = score_reg;
    assign state     = state_reg;
    assign game_over = game_over_reg;
    assign win       = win_reg;

endmodule
